// File: rtl/pc_pkg.sv
// pc_pkg: shared state encoding, widths and default vectors for the PC sequencer
package pc_pkg;
    typedef enum logic [1:0] {RUN, FLUSH, TRAP} state_t;
    localparam int XLEN = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEF_TRAP_VECTOR = 32'h0000_0100;
    localparam int DEF_FLUSH_CYCLES = 2;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: redirect requests in (stall, jump, branch, trap_ack); fetch PC, link, flush, trap status, statistics out
interface pc_sequencer_if;
    import pc_pkg::*;
    logic            stall;
    logic            jump_valid;
    logic            is_jalr;
    logic [XLEN-1:0] jump_target;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;
    logic            trap_ack;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            flush;
    logic            misalign_trap;
    logic [XLEN-1:0] trap_addr;
    logic [XLEN-1:0] redirect_count;
    modport master (
        output stall, jump_valid, is_jalr, jump_target, branch_taken, branch_target, trap_ack,
        input  pc, pc_plus4, flush, misalign_trap, trap_addr, redirect_count
    );
    modport slave (
        input  stall, jump_valid, is_jalr, jump_target, branch_taken, branch_target, trap_ack,
        output pc, pc_plus4, flush, misalign_trap, trap_addr, redirect_count
    );
endinterface

// File: rtl/pc_sequencer_next_pc_mux.sv
// next_pc_mux: priority next-PC select (jump > branch > pc+4), JALR bit0 clear, misalignment detect
module next_pc_mux
    import pc_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            jump_valid,
    input  logic            is_jalr,
    input  logic [XLEN-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] next_target,
    output logic            redirect,
    output logic            misaligned
);
    logic [XLEN-1:0] eff_jump;
    assign eff_jump = is_jalr ? {jump_target[XLEN-1:1], 1'b0} : jump_target;
    assign next_target = jump_valid ? eff_jump : branch_taken ? branch_target : pc + XLEN'(INSTR_BYTES);
    assign redirect = jump_valid | branch_taken;
    assign misaligned = redirect & (|next_target[1:0]);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, redirect FSM (RUN/FLUSH/TRAP), flush timer and misalignment trap
// Ports: clk, rst_n (async active-low), bus (pc_sequencer_if.slave: redirect inputs, pc/flush/trap outputs)
// Optional: PC_REDIRECT_COUNT_EN enables the redirect_count statistics register (tied to 0 otherwise)
module pc_sequencer
    import pc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR,
    parameter int              FLUSH_CYCLES = DEF_FLUSH_CYCLES
)(
    input logic clk,
    input logic rst_n,
    pc_sequencer_if.slave bus
);
    state_t          state, state_n;
    logic [XLEN-1:0] pc_q, pc_n, taddr_q, taddr_n, next_target;
    logic [3:0]      cnt_q, cnt_n;
    logic            redirect, misaligned;
    next_pc_mux u_mux (
        .pc(pc_q),
        .jump_valid(bus.jump_valid),
        .is_jalr(bus.is_jalr),
        .jump_target(bus.jump_target),
        .branch_taken(bus.branch_taken),
        .branch_target(bus.branch_target),
        .next_target(next_target),
        .redirect(redirect),
        .misaligned(misaligned)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            pc_q    <= RESET_VECTOR;
            taddr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_n;
            pc_q    <= pc_n;
            taddr_q <= taddr_n;
            cnt_q   <= cnt_n;
        end
    end
    // A misaligned redirect leaves pc untouched and parks in TRAP; stall only gates sequential advance.
    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        taddr_n = taddr_q;
        cnt_n   = cnt_q;
        if (state == TRAP) begin
            if (bus.trap_ack) begin
                state_n = FLUSH;
                pc_n    = TRAP_VECTOR;
                cnt_n   = 4'(FLUSH_CYCLES);
            end
        end else if (redirect && misaligned) begin
            state_n = TRAP;
            taddr_n = next_target;
        end else begin
            pc_n = (redirect || !bus.stall) ? next_target : pc_q;
            if (redirect) begin
                state_n = FLUSH;
                cnt_n   = 4'(FLUSH_CYCLES);
            end else if (state == FLUSH) begin
                cnt_n   = cnt_q - 4'd1;
                state_n = (cnt_q == 4'd1) ? RUN : FLUSH;
            end
        end
    end
    assign bus.pc            = pc_q;
    assign bus.pc_plus4      = pc_q + XLEN'(INSTR_BYTES);
    assign bus.flush         = state != RUN;
    assign bus.misalign_trap = state == TRAP;
    assign bus.trap_addr     = taddr_q;
`ifdef PC_REDIRECT_COUNT_EN
    logic            accept;
    logic [XLEN-1:0] rcount_q;
    assign accept = (state == TRAP) ? bus.trap_ack : (redirect && !misaligned);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rcount_q <= '0;
        else if (accept) rcount_q <= rcount_q + 1'b1;
    end
    assign bus.redirect_count = rcount_q;
`else
    assign bus.redirect_count = '0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plus randomized checks of pc_sequencer against a behavioural reference model
module tb_pc_sequencer;
    import pc_pkg::*;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    pc_sequencer_if bus();
    pc_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_pc, m_taddr, m_count;
    int m_left;
    bit m_trapped;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic check_all(input string tag);
        check({tag, ":pc"}, bus.pc, m_pc);
        check({tag, ":pc_plus4"}, bus.pc_plus4, m_pc + 32'd4);
        check({tag, ":flush"}, 32'(bus.flush), 32'(m_trapped || m_left > 0));
        check({tag, ":misalign"}, 32'(bus.misalign_trap), 32'(m_trapped));
        check({tag, ":trap_addr"}, bus.trap_addr, m_taddr);
`ifdef PC_REDIRECT_COUNT_EN
        check({tag, ":count"}, bus.redirect_count, m_count);
`else
        check({tag, ":count"}, bus.redirect_count, 32'h0);
`endif
    endtask
    task automatic model_reset();
        m_pc = DEF_RESET_VECTOR;
        m_taddr = 0;
        m_count = 0;
        m_left = 0;
        m_trapped = 0;
    endtask
    task automatic drive_idle();
        bus.stall = 0; bus.jump_valid = 0; bus.is_jalr = 0; bus.jump_target = 0;
        bus.branch_taken = 0; bus.branch_target = 0; bus.trap_ack = 0;
    endtask
    // One clock: drive inputs, let the edge happen, advance the model, compare on the falling edge.
    task automatic step(input bit st, input bit jv, input bit jalr, input logic [31:0] jt,
                        input bit br, input logic [31:0] bt, input bit ack, input string tag);
        logic [31:0] tgt;
        bus.stall = st; bus.jump_valid = jv; bus.is_jalr = jalr; bus.jump_target = jt;
        bus.branch_taken = br; bus.branch_target = bt; bus.trap_ack = ack;
        @(posedge clk);
        if (m_trapped) begin
            if (ack) begin
                m_trapped = 0;
                m_pc = DEF_TRAP_VECTOR;
                m_left = DEF_FLUSH_CYCLES;
                m_count++;
            end
        end else if (jv || br) begin
            tgt = jv ? (jalr ? jt & 32'hFFFF_FFFE : jt) : bt;
            if (tgt % 4 != 0) begin
                m_trapped = 1;
                m_taddr = tgt;
            end else begin
                m_pc = tgt;
                m_left = DEF_FLUSH_CYCLES;
                m_count++;
            end
        end else begin
            if (!st) m_pc = m_pc + 4;
            if (m_left > 0) m_left--;
        end
        @(negedge clk);
        check_all(tag);
    endtask
    task automatic idle(input string tag);
        step(0, 0, 0, 0, 0, 0, 0, tag);
    endtask
    function automatic logic [31:0] rnd_tgt();
        logic [31:0] r;
        r = $urandom();
        return ($urandom_range(0, 4) == 0) ? r : {r[31:2], 2'b00};
    endfunction
    logic [31:0] r_jt, r_bt, frozen;
    bit r_st, r_jv, r_jalr, r_br, r_ack;
    initial begin
        drive_idle();
        rst_n = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        check("reset_pc", bus.pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) idle("free");
        check("free_pc", bus.pc, 32'hC);
        step(0, 1, 0, 32'h40, 0, 0, 0, "jal");
        check("jal_pc", bus.pc, 32'h40);
        check("jal_flush", 32'(bus.flush), 32'h1);
        idle("jal_f1");
        check("jal_pc1", bus.pc, 32'h44);
        idle("jal_f2");
        check("jal_flush_end", 32'(bus.flush), 32'h0);
        step(0, 1, 1, 32'h81, 1, 32'h200, 0, "jalr");
        check("jalr_pc", bus.pc, 32'h80);
        idle("jalr_f1");
        idle("jalr_f2");
        step(0, 0, 0, 0, 1, 32'h102, 0, "mis");
        check("mis_trap", 32'(bus.misalign_trap), 32'h1);
        check("mis_addr", bus.trap_addr, 32'h102);
        frozen = bus.pc;
        for (int i = 0; i < 5; i++)
            step(1'($urandom()), 1'($urandom()), 1'($urandom()), rnd_tgt(), 1'($urandom()), rnd_tgt(), 0, "trap_hold");
        check("trap_frozen", bus.pc, frozen);
        step(0, 0, 0, 0, 0, 0, 1, "ack");
        check("ack_pc", bus.pc, 32'h100);
        check("ack_clear", 32'(bus.misalign_trap), 32'h0);
        idle("ack_f1");
        idle("ack_f2");
        step(1, 1, 0, 32'h20, 0, 0, 0, "stall_jmp");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, "stall");
        check("stall_pc", bus.pc, 32'h20);
        step(1, 1, 0, 32'h60, 0, 0, 0, "stall_redir");
        check("stall_redir_pc", bus.pc, 32'h60);
        step(0, 1, 0, 32'hFFFF_FFF8, 0, 0, 0, "wrap_jmp");
        idle("wrap1");
        check("wrap_plus4", bus.pc_plus4, 32'h0);
        idle("wrap2");
        check("wrap_pc", bus.pc, 32'h0);
        step(0, 1, 0, 32'h300, 0, 0, 0, "pre_rst");
        #2;
        rst_n = 1'b0;
        drive_idle();
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst_flush", 32'(bus.flush), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            r_st = ($urandom_range(0, 3) == 0);
            r_jv = ($urandom_range(0, 6) == 0);
            r_jalr = 1'($urandom());
            r_br = ($urandom_range(0, 6) == 0);
            r_ack = ($urandom_range(0, 2) == 0);
            r_jt = rnd_tgt();
            r_bt = rnd_tgt();
            step(r_st, r_jv, r_jalr, r_jt, r_br, r_bt, r_ack, "rand");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
